// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the FIFO family.
//   FIFO_STROBE / FIFO_EDGE : values for the EDGE_IN parameter of pcm_fifo
//                             (raw single-cycle strobes vs. level inputs whose
//                             release produces one strobe).
//   clog2()                 : ceiling log2, for sibling FIFOs that are sized
//                             by depth rather than by address bits.
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int unsigned FIFO_STROBE = 32'd0;
  localparam int unsigned FIFO_EDGE   = 32'd1;

  // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned n;
    v = value - 32'd1;
    n = 32'd0;
    while (v > 32'd0) begin
      v = v >> 1;
      n = n + 32'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/pcm_fifo_strobe_edge.sv
// ---------------------------------------------------------------------------
// strobe_edge
// Release detector: turns a level input (e.g. a pushbutton) into a single
// one-cycle strobe on its 1->0 transition, two clocks after the release.
// With BYPASS=1 the input is passed straight through as the strobe.
//   clock    : clock, posedge
//   reset    : synchronous active-high reset, clears both flops
//   i_in     : request input (level or strobe)
//   o_strobe : one-cycle request strobe
// ---------------------------------------------------------------------------
module strobe_edge #(
  parameter bit BYPASS = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_in,
  output logic o_strobe
);

  logic r_q1;
  logic r_q2;

  // Two-stage history of the input: r_q1 is the newest sample, r_q2 the older.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
    end else begin
      r_q1 <= i_in;
      r_q2 <= r_q1;
    end
  end

  // Older sample high and newer sample low marks a release.
  assign o_strobe = BYPASS ? i_in : (r_q2 & ~r_q1);

endmodule

// File: rtl/pcm_fifo.sv
// ---------------------------------------------------------------------------
// pcm_fifo
// Synchronous FIFO for the PCM sample path, depth 2**ABITS words of DBITS.
// Exact occupancy, programmable almost-full/almost-empty thresholds and
// sticky overflow/underflow flags. All outputs are registered.
//   clock, reset   : single clock (posedge), synchronous active-high reset
//   wr, din        : write request and data
//   rd             : read request; dout/dout_valid one cycle later
//   clr_err        : clears overflow/underflow (a same-cycle set wins)
//   dout           : read data, holds between accepted reads
//   dout_valid     : one-cycle pulse when dout was just updated
//   empty, full    : level == 0 / level == DEPTH
//   almost_empty   : level <= AE_LEVEL
//   almost_full    : level >= AF_LEVEL
//   level          : stored words, 0..DEPTH
//   overflow       : sticky, a write request was refused
//   underflow      : sticky, a read request was refused
// ---------------------------------------------------------------------------
module pcm_fifo
  import fifo_pkg::*;
#(
  parameter int DBITS    = 16,
  parameter int ABITS    = 7,
  parameter int AF_LEVEL = 2**ABITS - 4,
  parameter int AE_LEVEL = 4,
  parameter int EDGE_IN  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [DBITS-1:0] din,
  input  logic             clr_err,
  output logic [DBITS-1:0] dout,
  output logic             dout_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ABITS:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int           DEPTH   = 2**ABITS;
  localparam logic [ABITS:0] C_DEPTH = DEPTH[ABITS:0];
  localparam logic [ABITS:0] C_AF    = AF_LEVEL[ABITS:0];
  localparam logic [ABITS:0] C_AE    = AE_LEVEL[ABITS:0];
  localparam bit           C_BYPASS = (EDGE_IN != int'(FIFO_EDGE));

  logic [DBITS-1:0] r_mem [DEPTH];
  logic [ABITS-1:0] r_wr_ptr;
  logic [ABITS-1:0] r_rd_ptr;
  logic [ABITS:0]   r_level;
  logic [DBITS-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_empty;
  logic             r_full;
  logic             r_almost_empty;
  logic             r_almost_full;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_s;
  logic             w_rd_s;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [ABITS:0]   w_level_nxt;

  strobe_edge #(.BYPASS(C_BYPASS)) u_wr_edge (
    .clock    (clock),
    .reset    (reset),
    .i_in     (wr),
    .o_strobe (w_wr_s)
  );

  strobe_edge #(.BYPASS(C_BYPASS)) u_rd_edge (
    .clock    (clock),
    .reset    (reset),
    .i_in     (rd),
    .o_strobe (w_rd_s)
  );

  // A read frees a slot in the same cycle, so a full FIFO still takes a
  // write paired with a read. An empty FIFO never serves a read, even if a
  // write lands in the same cycle.
  assign w_rd_acc = w_rd_s & ~r_empty;
  assign w_wr_acc = w_wr_s & (~r_full | w_rd_acc);

  // Next occupancy: only an unpaired write or read moves the count.
  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_acc && !w_rd_acc) begin
      w_level_nxt = r_level + (ABITS+1)'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_level_nxt = r_level - (ABITS+1)'(1);
    end else begin
      w_level_nxt = r_level;
    end
  end

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers, occupancy, read port and flags, all from next-state values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_dout         <= '0;
      r_dout_valid   <= 1'b0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ABITS'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + ABITS'(1);
        r_dout   <= r_mem[r_rd_ptr];
      end
      r_dout_valid   <= w_rd_acc;
      r_level        <= w_level_nxt;
      r_empty        <= (w_level_nxt == '0);
      r_full         <= (w_level_nxt == C_DEPTH);
      r_almost_empty <= (w_level_nxt <= C_AE);
      r_almost_full  <= (w_level_nxt >= C_AF);
      // A refusal in the same cycle as clr_err keeps the flag set.
      if (w_wr_s && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_rd_s && !w_rd_acc) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign dout         = r_dout;
  assign dout_valid   = r_dout_valid;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_almost_empty;
  assign almost_full  = r_almost_full;
  assign level        = r_level;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_pcm_fifo.sv
// ---------------------------------------------------------------------------
// tb_pcm_fifo
// Bench for pcm_fifo: a strobe-mode instance (ABITS=3, AF=6, AE=2) checked
// against a queue-based reference model under directed and random traffic,
// and an edge-mode instance driven with directed press/release sequences.
// ---------------------------------------------------------------------------
module tb_pcm_fifo;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe-mode instance
  logic        reset = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        clr_err = 1'b0;
  logic [15:0] dout;
  logic        dout_valid, empty, full, almost_empty, almost_full;
  logic [3:0]  level;
  logic        overflow, underflow;

  // Edge-mode instance
  logic        e_reset = 1'b0;
  logic        e_wr = 1'b0;
  logic        e_rd = 1'b0;
  logic [15:0] e_din = 16'h0000;
  logic        e_clr = 1'b0;
  logic [15:0] e_dout;
  logic        e_dout_valid, e_empty, e_full, e_almost_empty, e_almost_full;
  logic [3:0]  e_level;
  logic        e_overflow, e_underflow;

  pcm_fifo #(.DBITS(16), .ABITS(3), .AF_LEVEL(6), .AE_LEVEL(2), .EDGE_IN(0)) dut (
    .clock(clock), .reset(reset), .wr(wr), .rd(rd), .din(din), .clr_err(clr_err),
    .dout(dout), .dout_valid(dout_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  pcm_fifo #(.DBITS(16), .ABITS(3), .AF_LEVEL(6), .AE_LEVEL(2), .EDGE_IN(1)) dut_e (
    .clock(clock), .reset(e_reset), .wr(e_wr), .rd(e_rd), .din(e_din), .clr_err(e_clr),
    .dout(e_dout), .dout_valid(e_dout_valid), .empty(e_empty), .full(e_full),
    .almost_empty(e_almost_empty), .almost_full(e_almost_full), .level(e_level),
    .overflow(e_overflow), .underflow(e_underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: FIFO contents as a queue plus sticky flags.
  logic [15:0] m_q [$];
  logic        m_ovf  = 1'b0;
  logic        m_udf  = 1'b0;
  logic [15:0] m_dout = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input logic exp_dv);
    int lvl;
    lvl = m_q.size();
    check("level",        32'(level),        32'(lvl));
    check("empty",        32'(empty),        32'(lvl == 0));
    check("full",         32'(full),         32'(lvl == 8));
    check("almost_empty", 32'(almost_empty), 32'(lvl <= 2));
    check("almost_full",  32'(almost_full),  32'(lvl >= 6));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_udf));
    check("dout",         32'(dout),         32'(m_dout));
    check("dout_valid",   32'(dout_valid),   32'(exp_dv));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = 16'h0000;
    check_all(1'b0);
  endtask

  // One clock of stimulus on the strobe-mode instance, model update, compare.
  task automatic step(input logic w, input logic r, input logic [15:0] d, input logic c);
    logic racc, wacc;
    int   lvl;
    wr = w; rd = r; din = d; clr_err = c;
    lvl  = m_q.size();
    racc = r && (lvl > 0);
    wacc = w && ((lvl < 8) || racc);
    if (racc) m_dout = m_q.pop_front();
    if (wacc) m_q.push_back(d);
    m_ovf = (w && !wacc) ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_udf = (r && !racc) ? 1'b1 : (c ? 1'b0 : m_udf);
    @(posedge clock); #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    check_all(racc);
  endtask

  task automatic e_cycle();
    @(posedge clock); #1;
  endtask

  initial begin
    int pw;
    int pr;

    #1;
    do_reset();

    // Fill 1..8: thresholds and full as level climbs.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(i), 1'b0);
    // Write while full is refused.
    step(1'b1, 1'b0, 16'h0099, 1'b0);
    // Drain in order.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0000, 1'b0);
    // Read on empty, then clear the error.
    step(1'b0, 1'b1, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);

    // Full FIFO with paired read+write for 20 cycles, then drain.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 16'h00AA + 16'(i), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0000, 1'b0);

    // Empty FIFO with paired read+write: write taken, read refused.
    step(1'b1, 1'b1, 16'h0055, 1'b0);
    step(1'b0, 1'b1, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1);

    // Random traffic with alternating fill/drain bias and occasional resets.
    for (int i = 0; i < 600; i++) begin
      pw = ((i / 40) % 2 == 0) ? 75 : 25;
      pr = 100 - pw;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
             16'($urandom), $urandom_range(0, 19) == 0);
      end
    end

    // Edge-mode instance: held wr gives one write, two clocks after release.
    e_reset = 1'b1; e_cycle(); e_reset = 1'b0;
    check("e_reset_level", 32'(e_level), 32'd0);
    check("e_reset_empty", 32'(e_empty), 32'd1);
    e_din = 16'h1234;
    e_wr  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e_cycle();
      check("e_hold_level", 32'(e_level), 32'd0);
    end
    e_wr = 1'b0;
    e_cycle();
    check("e_rel1_level", 32'(e_level), 32'd0);
    e_cycle();
    check("e_rel2_level", 32'(e_level), 32'd1);
    check("e_rel2_empty", 32'(e_empty), 32'd0);
    e_cycle();
    check("e_once_level", 32'(e_level), 32'd1);

    // Five more presses, then one read press: level 5, dout = first word.
    for (int i = 0; i < 5; i++) begin
      e_din = 16'h2000 + 16'(i);
      e_wr = 1'b1; e_cycle();
      e_wr = 1'b0; e_cycle(); e_cycle();
    end
    check("e_fill_level", 32'(e_level), 32'd6);
    e_rd = 1'b1; e_cycle();
    e_rd = 1'b0; e_cycle();
    check("e_rd_early_dv", 32'(e_dout_valid), 32'd0);
    e_cycle();
    check("e_rd_dv",    32'(e_dout_valid), 32'd1);
    check("e_rd_dout",  32'(e_dout),       32'h1234);
    check("e_rd_level", 32'(e_level),      32'd5);
    e_cycle();
    check("e_rd_dv_pulse", 32'(e_dout_valid), 32'd0);

    // Reset with level 5 discards contents and clears dout.
    e_reset = 1'b1; e_cycle(); e_reset = 1'b0;
    check("e_rst_level", 32'(e_level), 32'd0);
    check("e_rst_empty", 32'(e_empty), 32'd1);
    check("e_rst_dout",  32'(e_dout),  32'h0000);
    check("e_rst_ae",    32'(e_almost_empty), 32'd1);
    // First read after reset finds nothing.
    e_rd = 1'b1; e_cycle();
    e_rd = 1'b0; e_cycle(); e_cycle();
    check("e_post_rst_udf", 32'(e_underflow),  32'd1);
    check("e_post_rst_dv",  32'(e_dout_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
